// File: rtl/arc_microsequencer_if.sv
// arc_microsequencer_if: control-store/datapath bus of the ARC sequencer; master drives mir/ir/psr_*/mem_ready, slave (sequencer) drives cs_addr/mem_req/stall/halted/bus_err
interface arc_microsequencer_if;
  logic [40:0] mir;
  logic [31:0] ir;
  logic psr_n, psr_z, psr_v, psr_c, mem_ready;
  logic [10:0] cs_addr;
  logic mem_req, stall, halted, bus_err;
  modport master (
    output mir, ir, psr_n, psr_z, psr_v, psr_c, mem_ready,
    input cs_addr, mem_req, stall, halted, bus_err
  );
  modport slave (
    input mir, ir, psr_n, psr_z, psr_v, psr_c, mem_ready,
    output cs_addr, mem_req, stall, halted, bus_err
  );
endinterface

// File: rtl/arc_microsequencer.sv
// arc_microsequencer: ARC microcode next-address generator; ports clk, rst (sync, active-high), sq (slave: mir/ir/psr_*/mem_ready in, cs_addr/mem_req/stall/halted/bus_err out); define SEQ_WAIT_EN for mem_ready wait, WAIT_LIMIT timeout and bus_err
module arc_microsequencer #(
  parameter int WAIT_LIMIT = 255
) (
  input logic clk,
  input logic rst,
  arc_microsequencer_if.slave sq
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_nx;
  logic [10:0] cs_addr, seq, target;
  logic [2:0] cond;
  logic taken, halt_word, rw, waiting, timeout, bus_err, halted, mem_req, stall, adv;
  logic unused;
  assign cond = sq.mir[13:11];
  assign halt_word = &sq.mir;
  assign rw = sq.mir[19] | sq.mir[18];
  assign unused = ^{sq.mir[40:20], sq.mir[17:14], sq.ir[29:25], sq.ir[18:14], sq.ir[12:0]};
  always_comb begin
    seq = cs_addr + 11'd1;
    taken = cond == 3'd1 ? sq.psr_n :
            cond == 3'd2 ? sq.psr_z :
            cond == 3'd3 ? sq.psr_v :
            cond == 3'd4 ? sq.psr_c :
            cond == 3'd5 ? sq.ir[13] : cond == 3'd6;
    target = cond == 3'd7 ? {1'b1, sq.ir[31:30], sq.ir[24:19], 2'b00} : taken ? sq.mir[10:0] : seq;
  end
`ifdef SEQ_WAIT_EN
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  logic [CW-1:0] cnt;
  assign waiting = rw & ~halt_word & (state == RUN) & ~sq.mem_ready;
  assign timeout = waiting & (cnt == CW'(WAIT_LIMIT));
  always_ff @(posedge clk) begin
    cnt <= (rst | ~waiting | timeout) ? '0 : cnt + CW'(1);
    bus_err <= rst ? 1'b0 : bus_err | timeout;
  end
`else
  logic unused_cfg;
  assign waiting = 1'b0;
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
  assign unused_cfg = sq.mem_ready ^ (WAIT_LIMIT != 0);
`endif
  always_ff @(posedge clk) begin
    state <= rst ? RUN : state_nx;
    cs_addr <= rst ? '0 : adv ? target : cs_addr;
  end
  always_comb state_nx = (state == RUN && (halt_word || timeout)) ? HALT : state;
  always_comb begin
    halted = state == HALT;
    mem_req = rw & ~halted & ~halt_word;
    stall = halted | waiting;
    adv = ~halted & ~halt_word & ~waiting;
  end
  assign sq.cs_addr = cs_addr;
  assign sq.mem_req = mem_req;
  assign sq.stall = stall;
  assign sq.halted = halted;
  assign sq.bus_err = bus_err;
endmodule
